// File: rtl/brick_field_if.sv
// Bus between the breakout graphics top (master) and the brick wall engine (slave).
// BL_W must equal $clog2(ROWS*COLS+1) of the attached brick_field.
interface brick_field_if #(
  parameter int BL_W = 6
);
  logic            restart;
  logic            ball_tick;
  logic [9:0]      ball_x;
  logic [9:0]      ball_y;
  logic [9:0]      pix_x;
  logic [9:0]      pix_y;
  logic            busy;
  logic            done;
  logic            hit;
  logic            bounce_x;
  logic            bounce_y;
  logic            destroyed;
  logic [15:0]     score;
  logic [BL_W-1:0] bricks_left;
  logic            clear;
  logic            brick_on;
  logic [11:0]     brick_rgb;

  modport master (
    output restart, ball_tick, ball_x, ball_y, pix_x, pix_y,
    input  busy, done, hit, bounce_x, bounce_y, destroyed, score, bricks_left,
           clear, brick_on, brick_rgb
  );

  modport slave (
    input  restart, ball_tick, ball_x, ball_y, pix_x, pix_y,
    output busy, done, hit, bounce_x, bounce_y, destroyed, score, bricks_left,
           clear, brick_on, brick_rgb
  );
endinterface

// File: rtl/brick_field.sv
// Breakout brick wall: multi-hit brick grid, sequential one-brick-per-cycle
// ball collision scan, score / bricks-left bookkeeping and brick pixel render.
module brick_field #(
  parameter int COLS      = 8,
  parameter int ROWS      = 6,
  parameter int ORIGIN_X  = 40,
  parameter int ORIGIN_Y  = 30,
  parameter int BRICK_W   = 35,
  parameter int BRICK_H   = 20,
  parameter int MAX_HP    = 3,
  parameter int BALL_SIZE = 8
) (
  input logic         clk,
  input logic         reset,
  brick_field_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int NP    = 1 << IDX_W;
  localparam int BL_W  = $clog2(N + 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PENULT = IDX_W'(N - 2);

  typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;

  function automatic logic [1:0] init_hp(input int k);
    if (k >= N) return 2'd0;
    return 2'(MAX_HP - ((k / COLS) * MAX_HP) / ROWS);
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [10:0]       bxl_q, bxl_d, bxr_q, bxr_d, byt_q, byt_d, byb_q, byb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic              bounce_x_q, bounce_x_d;
  logic              bounce_y_q, bounce_y_d;
  logic              destroyed_q, destroyed_d;
  logic              clear_q, clear_d;
  logic [15:0]       score_q, score_d;
  logic [BL_W-1:0]   left_q, left_d;
  logic [1:0]        hp_q [NP];
  logic [1:0]        hp_d [NP];
  logic              brick_on_q, brick_on_d;
  logic [11:0]       rgb_q, rgb_d;

  logic [10:0]       ball_l, ball_r, ball_t, ball_b;
  logic [10:0]       px, py;
  logic [NP-1:0]     overlap;
  logic [NP-1:0]     side;
  logic [1:0]        cell_hp [NP];
  logic [1:0]        hp_pix;
  logic [16:0]       score_inc;
  logic              take_tick;

  assign ball_l = {1'b0, bus.ball_x};
  assign ball_t = {1'b0, bus.ball_y};
  assign ball_r = ball_l + 11'(BALL_SIZE - 1);
  assign ball_b = ball_t + 11'(BALL_SIZE - 1);
  assign px     = {1'b0, bus.pix_x};
  assign py     = {1'b0, bus.pix_y};

  // Per-cell comparators; indices past N are padding so idx_q can address any bit.
  for (genvar gi = 0; gi < NP; gi++) begin : g_cell
    if (gi < N) begin : g_live
      localparam logic [10:0] LEFT   = 11'(ORIGIN_X + (gi % COLS) * BRICK_W);
      localparam logic [10:0] RIGHT  = 11'(ORIGIN_X + (gi % COLS) * BRICK_W + BRICK_W - 1);
      localparam logic [10:0] TOP    = 11'(ORIGIN_Y + (gi / COLS) * BRICK_H);
      localparam logic [10:0] BOTTOM = 11'(ORIGIN_Y + (gi / COLS) * BRICK_H + BRICK_H - 1);
      assign overlap[gi] = (hp_q[gi] != 2'd0) && (LEFT <= bxr_q) && (bxl_q <= RIGHT)
                           && (TOP <= byb_q) && (byt_q <= BOTTOM);
      assign side[gi]    = ((bxl_q < LEFT) || (bxr_q > RIGHT))
                           && (byt_q >= TOP) && (byb_q <= BOTTOM);
      assign cell_hp[gi] = ((px >= LEFT) && (px < RIGHT) && (py >= TOP) && (py < BOTTOM))
                           ? hp_q[gi] : 2'd0;
    end else begin : g_pad
      assign overlap[gi] = 1'b0;
      assign side[gi]    = 1'b0;
      assign cell_hp[gi] = 2'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bxl_d       = bxl_q;
    bxr_d       = bxr_q;
    byt_d       = byt_q;
    byb_d       = byb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hit_d       = 1'b0;
    bounce_x_d  = 1'b0;
    bounce_y_d  = 1'b0;
    destroyed_d = 1'b0;
    clear_d     = 1'b0;
    score_d     = score_q;
    left_d      = left_q;
    hp_d        = hp_q;
    take_tick   = 1'b0;
    score_inc   = {1'b0, score_q} + (destroyed_q ? 17'd5 : 17'd1);

    if (bus.restart) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      score_d = 16'd0;
      left_d  = BL_W'(N);
      for (int k = 0; k < NP; k++) hp_d[k] = init_hp(k);
    end else begin
      unique case (state_q)
        IDLE: take_tick = bus.ball_tick;
        SCAN: begin
          if (overlap[idx_q]) begin
            state_d     = HIT;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            hit_d       = 1'b1;
            bounce_x_d  = side[idx_q];
            bounce_y_d  = !side[idx_q];
            destroyed_d = (hp_q[idx_q] == 2'd1);
            clear_d     = (hp_q[idx_q] == 2'd1) && (left_q == BL_W'(1));
          // Looking one brick ahead lets a full miss report done in the cycle
          // that compares the last brick.
          end else if ((idx_q == LAST) || ((idx_q == PENULT) && !overlap[N-1])) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        HIT: begin
          hp_d[idx_q] = hp_q[idx_q] - 2'd1;
          score_d     = score_inc[16] ? 16'hFFFF : score_inc[15:0];
          if (destroyed_q) left_d = left_q - 1'b1;
          state_d   = IDLE;
          take_tick = bus.ball_tick;
        end
        default: state_d = IDLE;
      endcase

      if (take_tick) begin
        bxl_d   = ball_l;
        bxr_d   = ball_r;
        byt_d   = ball_t;
        byb_d   = ball_b;
        idx_d   = '0;
        state_d = SCAN;
        busy_d  = 1'b1;
      end
    end
  end

  always_comb begin
    hp_pix = 2'd0;
    for (int k = 0; k < NP; k++) hp_pix = hp_pix | cell_hp[k];
    brick_on_d = (hp_pix != 2'd0);
    unique case (hp_pix)
      2'd3:    rgb_d = 12'hf00;
      2'd2:    rgb_d = 12'hf80;
      2'd1:    rgb_d = 12'h0f0;
      default: rgb_d = 12'h000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bxl_q       <= '0;
      bxr_q       <= '0;
      byt_q       <= '0;
      byb_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
      destroyed_q <= 1'b0;
      clear_q     <= 1'b0;
      score_q     <= 16'd0;
      left_q      <= BL_W'(N);
      for (int k = 0; k < NP; k++) hp_q[k] <= init_hp(k);
      brick_on_q  <= 1'b0;
      rgb_q       <= 12'h000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bxl_q       <= bxl_d;
      bxr_q       <= bxr_d;
      byt_q       <= byt_d;
      byb_q       <= byb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      bounce_x_q  <= bounce_x_d;
      bounce_y_q  <= bounce_y_d;
      destroyed_q <= destroyed_d;
      clear_q     <= clear_d;
      score_q     <= score_d;
      left_q      <= left_d;
      hp_q        <= hp_d;
      brick_on_q  <= brick_on_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hit         = hit_q;
  assign bus.bounce_x    = bounce_x_q;
  assign bus.bounce_y    = bounce_y_q;
  assign bus.destroyed   = destroyed_q;
  assign bus.clear       = clear_q;
  assign bus.score       = score_q;
  assign bus.bricks_left = left_q;
  assign bus.brick_on    = brick_on_q;
  assign bus.brick_rgb   = rgb_q;
endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: stimulus pushes expected scan results,
// a negedge monitor pops them when done pulses.
`timescale 1ns/1ps
module tb_brick_field;
  localparam int N = 48;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  brick_field_if #(.BL_W(6)) bus ();
  brick_field dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int done_cyc;
    int hit;
    int bx;
    int by;
    int destroyed;
    int clear;
    int score;
    int left;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t post_exp;
  bit   post_pending = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   clear_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (post_pending) begin
        check("score", int'(bus.score), post_exp.score);
        check("bricks_left", int'(bus.bricks_left), post_exp.left);
        post_pending = 1'b0;
      end
      if (bus.clear) clear_count++;
      if (!bus.done && (bus.hit || bus.bounce_x || bus.bounce_y || bus.destroyed || bus.clear))
        check("stray_pulse",
              int'({bus.hit, bus.bounce_x, bus.bounce_y, bus.destroyed, bus.clear}), 0);
      if (bus.done) begin
        done_count++;
        if (sb.size() == 0) begin
          check("unexpected_done", int'(bus.done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("hit", int'(bus.hit), mon_e.hit);
          check("bounce_x", int'(bus.bounce_x), mon_e.bx);
          check("bounce_y", int'(bus.bounce_y), mon_e.by);
          check("destroyed", int'(bus.destroyed), mon_e.destroyed);
          check("clear", int'(bus.clear), mon_e.clear);
          $display("scan cyc=%0d hit=%0b bx=%0b by=%0b destroyed=%0b clear=%0b",
                   cyc, bus.hit, bus.bounce_x, bus.bounce_y, bus.destroyed, bus.clear);
          post_exp     = mon_e;
          post_pending = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || post_pending) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      check("scan_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic push_exp(input int dcyc, input int hit, input int bx, input int by,
                          input int des, input int clr, input int score, input int left);
    exp_t e;
    e.done_cyc  = dcyc;
    e.hit       = hit;
    e.bx        = bx;
    e.by        = by;
    e.destroyed = des;
    e.clear     = clr;
    e.score     = score;
    e.left      = left;
    sb.push_back(e);
  endtask

  // idx < 0 means a full miss.
  task automatic run_tick(input int x, input int y, input int idx, input int hit,
                          input int bx, input int by, input int des, input int clr,
                          input int score, input int left, input bit chk_busy);
    int t;
    t = cyc;
    push_exp((idx < 0) ? t + N : t + 2 + idx, hit, bx, by, des, clr, score, left);
    bus.ball_x    = 10'(x);
    bus.ball_y    = 10'(y);
    bus.ball_tick = 1'b1;
    step();
    bus.ball_tick = 1'b0;
    if (chk_busy) begin
      for (int j = 1; j <= N; j++) begin
        @(negedge clk);
        check("busy_window", int'(bus.busy), (j <= N - 1) ? 1 : 0);
      end
    end
    wait_idle();
  endtask

  task automatic render(input int x, input int y, input int on, input int rgb);
    bus.pix_x = 10'(x);
    bus.pix_y = 10'(y);
    step();
    @(negedge clk);
    check("brick_on", int'(bus.brick_on), on);
    check("brick_rgb", int'(bus.brick_rgb), rgb);
    $display("pixel (%0d,%0d) on=%0b rgb=%03h", x, y, bus.brick_on, bus.brick_rgb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int cc;
    int t;
    int hp_m [N];
    int score_m;
    int left_m;
    int des;
    int clr;

    bus.restart   = 1'b0;
    bus.ball_tick = 1'b0;
    bus.ball_x    = '0;
    bus.ball_y    = '0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_bricks_left", int'(bus.bricks_left), 48);
    check("rst_score", int'(bus.score), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_hit", int'(bus.hit), 0);
    check("rst_bounce", int'({bus.bounce_x, bus.bounce_y}), 0);
    check("rst_destroyed", int'(bus.destroyed), 0);
    check("rst_clear", int'(bus.clear), 0);
    check("rst_brick_on", int'(bus.brick_on), 0);
    check("rst_rgb", int'(bus.brick_rgb), 0);

    render(41, 31, 1, 'hf00);
    render(74, 31, 0, 'h000);

    // Brick 0 and brick 8 both overlap; brick 0 wins, top-face hit.
    run_tick(50, 45, 0, 1, 0, 1, 0, 0, 1, 48, 1'b0);
    render(41, 31, 1, 'hf80);
    // Side hit on brick 0.
    run_tick(34, 35, 0, 1, 1, 0, 0, 0, 2, 48, 1'b0);
    render(41, 31, 1, 'h0f0);
    // Far miss with busy window check.
    run_tick(300, 400, -1, 0, 0, 0, 0, 0, 2, 48, 1'b1);
    // Brick 40 has 1 HP: destroyed, +5.
    run_tick(50, 135, 40, 1, 0, 1, 1, 0, 7, 47, 1'b0);
    render(41, 131, 0, 'h000);
    render(41, 111, 1, 'h0f0);
    run_tick(50, 135, -1, 0, 0, 0, 0, 0, 7, 47, 1'b0);

    // Second tick while busy is ignored.
    dc = done_count;
    t  = cyc;
    push_exp(t + N, 0, 0, 0, 0, 0, 7, 47);
    bus.ball_x = 10'd300;
    bus.ball_y = 10'd400;
    bus.ball_tick = 1'b1;
    step();
    bus.ball_tick = 1'b0;
    step();
    step();
    bus.ball_x = 10'd50;
    bus.ball_y = 10'd45;
    bus.ball_tick = 1'b1;
    step();
    bus.ball_tick = 1'b0;
    wait_idle();
    repeat (60) step();
    check("ignored_tick_dones", done_count - dc, 1);

    // Restart aborts a scan in flight.
    dc = done_count;
    bus.ball_x = 10'd300;
    bus.ball_y = 10'd400;
    bus.ball_tick = 1'b1;
    step();
    bus.ball_tick = 1'b0;
    repeat (4) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    @(negedge clk);
    check("restart_busy", int'(bus.busy), 0);
    check("restart_score", int'(bus.score), 0);
    check("restart_bricks_left", int'(bus.bricks_left), 48);
    repeat (60) step();
    check("restart_no_done", done_count - dc, 0);
    render(41, 31, 1, 'hf00);

    // Knock out every brick in index order.
    cc      = clear_count;
    score_m = 0;
    left_m  = 48;
    for (int k = 0; k < N; k++) hp_m[k] = 3 - ((k / 8) * 3) / 6;
    for (int k = 0; k < N; k++) begin
      while (hp_m[k] > 0) begin
        des = (hp_m[k] == 1) ? 1 : 0;
        clr = (des == 1 && left_m == 1) ? 1 : 0;
        score_m += (des == 1) ? 5 : 1;
        left_m  -= des;
        hp_m[k]--;
        run_tick(40 + (k % 8) * 35 + 10, 30 + (k / 8) * 20 + 5, k,
                 1, 0, 1, des, clr, score_m, left_m, 1'b0);
      end
    end
    check("clear_pulses", clear_count - cc, 1);
    check("final_bricks_left", int'(bus.bricks_left), 0);
    check("final_score", int'(bus.score), 288);
    run_tick(50, 45, -1, 0, 0, 0, 0, 0, 288, 0, 1'b0);
    render(41, 31, 0, 'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/brick_field.md
# brick_field

Parametrised brick-wall engine for the breakout display path. Holds a ROWS×COLS grid of multi-hit bricks, resolves ball/brick collisions with a sequential scan once per ball update, and keeps score, bricks-remaining count and field-clear status. It also renders brick pixels for the RGB mux; the paddle, ball motion and the final colour priority stay in the graphics top level.

## Interface
- COLS, 8, brick columns
- ROWS, 6, brick rows
- ORIGIN_X, 40, left pixel of the field
- ORIGIN_Y, 30, top pixel of the field
- BRICK_W, 35, cell width in pixels (last pixel column is mortar)
- BRICK_H, 20, cell height in pixels (last pixel row is mortar)
- MAX_HP, 3, maximum hit points per brick (1..3)
- BALL_SIZE, 8, ball bounding-box side in pixels
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- restart  in  1  synchronous field reload (the gra_still equivalent)
- ball_tick  in  1  one-cycle pulse: ball position updated
- ball_x, ball_y  in  10 each  ball top-left corner
- pix_x, pix_y  in  10 each  current scan pixel
- busy  out  1  collision scan in progress
- done  out  1  one-cycle pulse when a scan ends
- hit  out  1  one-cycle pulse with done when a brick was struck
- bounce_x, bounce_y  out  1 each  valid with hit: reverse x / y velocity
- destroyed  out  1  valid with hit: the struck brick reached 0 HP
- score  out  16  accumulated score
- bricks_left  out  clog2(ROWS*COLS+1)  live brick count
- clear  out  1  one-cycle pulse when bricks_left goes to 0
- brick_on  out  1  pixel belongs to a live brick
- brick_rgb  out  12  brick colour for the pixel

## Operation
- Brick index k = row*COLS + col. Cell bounds: left = ORIGIN_X+col*BRICK_W, right = left+BRICK_W-1, top = ORIGIN_Y+row*BRICK_H, bottom = top+BRICK_H-1.
- Initial HP of row r = MAX_HP − (r*MAX_HP)/ROWS. Defaults give rows 0..5 HP 3,3,2,2,1,1. HP is stored in a 2-bit value per brick. Brick is live when HP ≠ 0.
- Reset and restart load every brick with its initial HP, set bricks_left=ROWS*COLS and score=0, and put the FSM in IDLE.
- Ball box: bx_l=ball_x, bx_r=ball_x+BALL_SIZE−1, by_t=ball_y, by_b=ball_y+BALL_SIZE−1. Compute in 11 bits; no wrap.
- FSM states:
  - IDLE: on ball_tick, latch the ball coordinates, set index=0, go to SCAN.
  - SCAN: compare one brick per cycle. Overlap means live && left≤bx_r && bx_l≤right && top≤by_b && by_t≤bottom. The first overlap goes to HIT. When index=N−1 with no overlap, go to IDLE and pulse done.
  - HIT: one cycle. Decrement that brick's HP and pulse done and hit.
- Side rule on a hit:
  - bounce_x=1 when (bx_l<left || bx_r>right) && by_t≥top && by_b≤bottom.
  - Otherwise bounce_y=1. Corner cases resolve to bounce_y. Exactly one bounce bit is set.
- Only one brick is struck per scan; the lowest index wins.
- Score:
  - +1 per hit.
  - +4 extra when destroyed, i.e. +5 total.
  - Saturates at 16'hFFFF.
- bricks_left decrements on destroyed. clear pulses in the same cycle that bricks_left goes from 1 to 0.
- Render: the pixel is inside a cell and not on its mortar row/column, and that brick is live. Colour by HP: 3→12'hf00, 2→12'hf80, 1→12'h0f0. When brick_on=0, brick_rgb=12'h000.

## Timing
- Reset values: busy, done, hit, bounce_x, bounce_y, destroyed, clear, brick_on =0; brick_rgb=0; score=0; bricks_left=ROWS*COLS.
- With ball_tick at cycle T, brick i is compared in cycle T+1+i, and busy is high in T+1..T+1+i.
  - On a hit, hit/done/bounce/destroyed pulse at T+2+i, and HP, score and bricks_left update at the same edge (visible at T+3+i). busy is low at T+2+i.
  - On a miss, done pulses at T+N and busy is low from T+N.
- ball_tick is ignored while busy=1.
- restart has priority over everything: a scan in flight is aborted with no done/hit, and the field is reloaded next edge.
- Render latency is 1 cycle: brick_on/brick_rgb at cycle t+1 correspond to pix_x/pix_y at cycle t. An HP change is reflected from the next pixel sampled after the update edge.

## Test plan
- Reset → bricks_left=48, score=0, all pulse outputs 0. Pixel (41,31) → brick_on=1 and rgb=12'hf00 one cycle later. Mortar pixel (74,31) → brick_on=0.
- ball (50,45), tick at T → brick 0 struck (lowest index, although brick 8 also overlaps). hit/done/bounce_y at T+2. HP 3→2, score=1, destroyed=0. Pixel (41,31) then renders 12'hf80.
- ball (34,35) → side hit on brick 0: bounce_x=1, bounce_y=0. ball (300,400), far from all bricks → done at T+48, hit=0, busy high T+1..T+47.
- Strike brick 40 (row 5, HP 1) → destroyed=1, score +5, bricks_left 48→47. Repeating the same ball position → no hit, because the brick is dead.
- Clear all 48 bricks (force-load HP=1) → clear pulses once, together with the final destroyed. A second ball_tick during busy is ignored, with no extra done.
- restart asserted mid-scan at T+5 → busy=0 at T+6, no hit/done pulse, score=0, bricks_left=48, brick 0 back to HP 3.
